// File: rtl/result_tx_serializer.sv
// Result transmit serializer.
// Reads an N x N result matrix from a synchronous RAM in row-major order.
// Each element is sent to the UART transmitter one byte at a time, most significant byte first.
// The block pulses done once the last byte has left the transmitter.
module result_tx_serializer #(
   parameter int unsigned MAX_N  = 8,
   parameter int unsigned ELEM_W = 16,
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        matrix_size,
   output logic [ADDR_W-1:0] res_addr,
   input  logic [ELEM_W-1:0] res_data,
   output logic [7:0]        tx_data,
   output logic              tx_load,
   input  logic              tx_busy,
   output logic              busy,
   output logic              done
);

   localparam int unsigned BYTES = ELEM_W / 8;
   localparam int unsigned BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int unsigned TOT_W = 7;

   localparam logic [3:0]      MAX_N_L   = 4'(MAX_N);
   localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_WAIT_TX,
      S_LOAD,
      S_GAP,
      S_DONE
   } state_t;

   state_t            state;
   logic [TOT_W-1:0]  total;
   logic [TOT_W-1:0]  elem_idx;
   logic [BI_W-1:0]   byte_idx;
   logic [ELEM_W-1:0] shift_reg;

   logic [3:0]        n_eff_c;
   logic [TOT_W-1:0]  total_c;

   // Clamp the requested dimension and derive the element count for a new transfer
   always_comb begin
      n_eff_c = (matrix_size > MAX_N_L) ? MAX_N_L : matrix_size;
      total_c = TOT_W'(n_eff_c) * TOT_W'(n_eff_c);
   end

   // Transfer FSM with registered outputs.
   // tx_data and tx_load are set on entry to LOAD so that the byte is already stable in the load cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         res_addr  <= '0;
         tx_data   <= '0;
         tx_load   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         total     <= '0;
         elem_idx  <= '0;
         byte_idx  <= '0;
         shift_reg <= '0;
      end else begin
         tx_load <= 1'b0;
         done    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  total    <= total_c;
                  elem_idx <= '0;
                  res_addr <= '0;
                  busy     <= 1'b1;
                  state    <= (n_eff_c == 4'd0) ? S_DONE : S_FETCH;
               end
            end
            S_FETCH: begin
               state <= S_LATCH;
            end
            S_LATCH: begin
               shift_reg <= res_data;
               byte_idx  <= '0;
               state     <= S_WAIT_TX;
            end
            S_WAIT_TX: begin
               if (!tx_busy) begin
                  tx_data <= shift_reg[ELEM_W-1 -: 8];
                  tx_load <= 1'b1;
                  state   <= S_LOAD;
               end
            end
            S_LOAD: begin
               shift_reg <= shift_reg << 8;
               state     <= S_GAP;
            end
            S_GAP: begin
               if (byte_idx < LAST_BYTE) begin
                  byte_idx <= byte_idx + BI_W'(1);
                  state    <= S_WAIT_TX;
               end else if (elem_idx < (total - TOT_W'(1))) begin
                  elem_idx <= elem_idx + TOT_W'(1);
                  res_addr <= ADDR_W'(elem_idx + TOT_W'(1));
                  state    <= S_FETCH;
               end else begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               if (!tx_busy) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_result_tx_serializer.sv
// Testbench for result_tx_serializer.
// A scoreboard queue of expected bytes is filled from the matrix contents.
// A negedge monitor pops and compares on every tx_load.
module tb_result_tx_serializer;

   localparam int unsigned MAX_N  = 8;
   localparam int unsigned ELEM_W = 16;
   localparam int unsigned ADDR_W = 6;
   localparam int unsigned BYTES  = ELEM_W / 8;
   localparam int unsigned FRAME  = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [3:0]        matrix_size = '0;
   logic [ADDR_W-1:0] res_addr;
   logic [ELEM_W-1:0] res_data;
   logic [7:0]        tx_data;
   logic              tx_load;
   logic              tx_busy;
   logic              busy;
   logic              done;

   logic              ext_busy = 1'b0;
   int                uart_cnt = 0;
   int                stretch_max = 0;
   logic [ELEM_W-1:0] ram [64];

   logic [7:0]        exp_q[$];
   logic [7:0]        exp_b;
   int                addr_seq[$];
   bit                seen_busy = 1'b0;
   int                last_addr = 0;
   int                checks = 0;
   int                fails = 0;
   int                loads = 0;
   int                done_cnt = 0;
   int                busy_cyc = 0;

   result_tx_serializer #(.MAX_N(MAX_N), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .matrix_size(matrix_size),
      .res_addr(res_addr), .res_data(res_data), .tx_data(tx_data),
      .tx_load(tx_load), .tx_busy(tx_busy), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Synchronous result RAM: data one cycle after the address
   always @(posedge clk) res_data <= ram[res_addr];

   // UART model: busy from the cycle after a load for a (possibly stretched) frame
   always @(posedge clk) begin
      if (tx_load) uart_cnt <= FRAME + $urandom_range(0, stretch_max);
      else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
   end
   assign tx_busy = (uart_cnt != 0) || ext_busy;

   task automatic check(input bit ok, input string name, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: byte scoreboard, handshake rules, done/busy accounting
   always @(negedge clk) begin
      if (!rst) begin
         if (tx_load) begin
            loads++;
            check(!tx_busy, "load_while_busy", longint'(tx_busy), 0);
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_byte", longint'(tx_data), 0);
            end else begin
               exp_b = exp_q.pop_front();
               check(tx_data == exp_b, "tx_byte", longint'(tx_data), longint'(exp_b));
            end
         end
         if (done) begin
            done_cnt++;
            check(!tx_busy, "done_before_tx_idle", longint'(tx_busy), 0);
         end
         if (busy) begin
            busy_cyc++;
            if (!seen_busy || int'(res_addr) != last_addr) begin
               addr_seq.push_back(int'(res_addr));
               last_addr = int'(res_addr);
               seen_busy = 1'b1;
            end
         end
      end
   end

   task automatic push_expected(input int total);
      for (int i = 0; i < total; i++)
         for (int b = int'(BYTES) - 1; b >= 0; b--)
            exp_q.push_back(8'(ram[i] >> (8 * b)));
   endtask

   // Run one transfer, optionally with foreign TX traffic or a mid-transfer start poke
   task automatic run_xfer(input int msz, input bit hold50, input bit poke);
      int n, total, d0, guard;
      bit ok;
      n     = (msz > int'(MAX_N)) ? int'(MAX_N) : msz;
      total = n * n;
      push_expected(total);
      loads     = 0;
      busy_cyc  = 0;
      addr_seq.delete();
      seen_busy = 1'b0;
      d0        = done_cnt;
      @(negedge clk);
      if (hold50) ext_busy = 1'b1;
      matrix_size = 4'(msz);
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
      matrix_size = 4'($urandom_range(0, 15));
      if (hold50) begin
         repeat (50) @(negedge clk);
         ext_busy = 1'b0;
      end
      if (poke) begin
         repeat (20) @(negedge clk);
         start       = 1'b1;
         matrix_size = 4'd5;
         @(negedge clk);
         start       = 1'b0;
      end
      guard = 0;
      while (done_cnt == d0 && guard < 30000) begin
         @(posedge clk);
         guard++;
      end
      repeat (6) @(posedge clk);
      check(done_cnt == d0 + 1, "done_pulses", done_cnt - d0, 1);
      check(loads == int'(BYTES) * total, "load_count", loads, int'(BYTES) * total);
      check(exp_q.size() == 0, "bytes_left", exp_q.size(), 0);
      if (total == 0) begin
         check(busy_cyc == 1, "busy_cycles_n0", busy_cyc, 1);
      end else begin
         ok = (addr_seq.size() == total);
         foreach (addr_seq[i]) if (addr_seq[i] != i) ok = 1'b0;
         check(ok, "addr_sequence", addr_seq.size(), total);
      end
      exp_q.delete();
   endtask

   initial begin
      int guard, dbefore;
      for (int i = 0; i < 64; i++) ram[i] = '0;

      // Reset values
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check(res_addr == '0, "rst_res_addr", longint'(res_addr), 0);
      check(tx_data == '0, "rst_tx_data", longint'(tx_data), 0);
      check(!tx_load, "rst_tx_load", longint'(tx_load), 0);
      check(!busy, "rst_busy", longint'(busy), 0);
      check(!done, "rst_done", longint'(done), 0);
      rst = 1'b0;
      @(posedge clk);

      // Basic N=2 stream
      ram[0] = 16'h0102; ram[1] = 16'h0304; ram[2] = 16'h0506; ram[3] = 16'h0708;
      run_xfer(2, 1'b0, 1'b0);

      // Empty matrix
      run_xfer(0, 1'b0, 1'b0);

      // Clamp 9 -> 8
      for (int i = 0; i < 64; i++) ram[i] = 16'(i);
      run_xfer(9, 1'b0, 1'b0);

      // Foreign traffic before the first byte and stretched frames
      for (int i = 0; i < 64; i++) ram[i] = 16'($urandom);
      stretch_max = 6;
      run_xfer(3, 1'b1, 1'b0);
      stretch_max = 0;

      // Start poke and size change mid-transfer are ignored
      run_xfer(2, 1'b0, 1'b1);

      // Random sizes and data
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 64; i++) ram[i] = 16'($urandom);
         stretch_max = int'($urandom_range(0, 4));
         run_xfer(int'($urandom_range(1, 15)), 1'b0, 1'b0);
      end
      stretch_max = 0;

      // Reset during element 2 of N=3
      for (int i = 0; i < 9; i++) ram[i] = 16'($urandom);
      push_expected(9);
      loads   = 0;
      dbefore = done_cnt;
      @(negedge clk);
      matrix_size = 4'd3;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (loads < 5 && guard < 5000) begin
         @(posedge clk);
         guard++;
      end
      check(loads >= 5, "reach_elem2", loads, 5);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check(res_addr == '0, "midrst_res_addr", longint'(res_addr), 0);
      check(tx_data == '0, "midrst_tx_data", longint'(tx_data), 0);
      check(!tx_load, "midrst_tx_load", longint'(tx_load), 0);
      check(!busy, "midrst_busy", longint'(busy), 0);
      check(!done, "midrst_done", longint'(done), 0);
      @(negedge clk);
      exp_q.delete();
      rst = 1'b0;
      check(done_cnt == dbefore, "no_done_after_abort", done_cnt - dbefore, 0);
      @(posedge clk);
      ram[0] = 16'hABCD;
      run_xfer(1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/result_tx_serializer.md
Name: result_tx_serializer

Overview:
Downstream stage of the matrix-multiply control path. When the controller enters its send phase, this block reads the N×N result matrix from the result RAM in row-major order. It serialises each ELEM_W-bit element into bytes, MSB first, and hands them one at a time to the UART transmitter using a load/busy handshake. It pulses done after the last byte has fully left the transmitter.

Parameters:
MAX_N, 8, largest supported matrix dimension; matrix_size above this is clamped to MAX_N
ELEM_W, 16, result element width in bits; must be a multiple of 8 (BYTES = ELEM_W/8)
ADDR_W, 6, result RAM address width; must satisfy 2^ADDR_W >= MAX_N*MAX_N

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  level request from controller; sampled only in IDLE
matrix_size  in  4  N; latched when start is accepted
res_addr  out  ADDR_W  result RAM read address (registered)
res_data  in  ELEM_W  result RAM read data; valid 1 cycle after res_addr changes (sync RAM)
tx_data  out  8  byte to UART TX; held stable from the tx_load cycle until the next load
tx_load  out  1  1-cycle pulse: UART TX captures tx_data
tx_busy  in  1  UART TX busy; rises the cycle after tx_load, falls when the stop bit completes
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse at end of transfer

Behaviour:
- Reset (async, any state, including mid-transfer):
  - state=IDLE; res_addr=0, tx_data=0, tx_load=0, busy=0, done=0.
  - Element, byte and size registers cleared.
  - No partial byte is retried after reset.
- States: IDLE, FETCH, LATCH, WAIT_TX, LOAD, GAP, DONE.
- IDLE:
  - If start=1, latch n_eff = min(matrix_size, MAX_N) and total = n_eff*n_eff (7-bit, max 64).
  - Set elem_idx=0, res_addr=0.
  - Go to DONE if n_eff==0, else FETCH.
  - start=0: stay.
- FETCH: one cycle while the RAM reads res_addr -> LATCH.
- LATCH: shift_reg <= res_data; byte_idx <= 0 -> WAIT_TX.
- WAIT_TX: wait while tx_busy=1; on tx_busy=0 -> LOAD.
- LOAD:
  - tx_data <= shift_reg[ELEM_W-1 -: 8], tx_load=1 for exactly this cycle.
  - shift_reg <<= 8 -> GAP.
- GAP: one cycle that absorbs the UART busy-rise latency, then:
  - byte_idx < BYTES-1: byte_idx+1 -> WAIT_TX.
  - Last byte and elem_idx < total-1: elem_idx+1, res_addr <= elem_idx+1 -> FETCH.
  - Last byte of last element -> DONE.
- DONE:
  - Entered after the final GAP; wait in DONE until tx_busy=0 so the last byte is on the wire.
  - Then done=1 for one cycle -> IDLE.
  - For n_eff=0, done pulses the cycle after entry.
- Timing:
  - Start accept to first tx_load = 4 cycles when tx_busy=0 (IDLE->FETCH->LATCH->WAIT_TX->LOAD).
  - With an idle TX, consecutive bytes are ≥ 3 cycles apart; in practice the UART frame length governs.
- Byte order: element 0 first, row-major (addr = row*n_eff + col), MSB byte first within each element.
- start held high through DONE does not retrigger in the done cycle. It is re-sampled in IDLE the following cycle, so a level-held start restarts the transfer; the controller must drop start on done.
- start while busy=1: ignored; matrix_size changes mid-transfer are ignored (latched copy used).
- tx_busy already high on entry to WAIT_TX (foreign traffic): block waits, never drops or overwrites a byte.
- tx_load is never asserted while tx_busy=1.
- Exactly BYTES*total tx_load pulses per transfer.

Test Plan:
- N=2, ELEM_W=16, RAM={0x0102,0x0304,0x0506,0x0708}, UART model 10-cycle busy -> bytes 01 02 03 04 05 06 07 08 in order; one done pulse after the last busy falls; res_addr visits 0,1,2,3.
- N=0, start=1 -> no tx_load; done pulses exactly once; busy high for 1 cycle (DONE) only.
- N=9 (clamp), RAM[i]=i -> 128 bytes, 64 elements, last element 0x003F sent as 00 3F; res_addr never exceeds 63.
- tx_busy held high 50 cycles before the first byte and randomly stretched afterwards -> tx_load never coincides with tx_busy=1; byte stream unchanged.
- Assert rst mid-way through element 2 of N=3 -> outputs immediately 0, state IDLE. A new start with N=1, RAM[0]=0xABCD -> bytes AB CD, then done.
- start pulsed again and matrix_size changed during an N=2 transfer -> ignored; exactly 8 bytes sent and one done pulse.
